memory_arbiter: RTL and testbench

// - Shares the single external memory port between three pipeline requesters:
//   - fetch (instruction words);
//   - read stage (data operand loads, address_enable/address/data_valid handshake);
//   - write stage (stores).
// - Sits between the pipeline stages and the memory controller.
// - One transaction is in flight at a time.
// - Registers each granted request and returns the result as a 1-cycle valid pulse
//   to the owner.

---
 rtl/memory_arbiter_if.sv | 39 +++
 rtl/memory_arbiter.sv | 152 +++++++++++++++
 tb/tb_memory_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// Bundle of the three pipeline requester handshakes plus the memory controller port.
// master: the arbiter's view; slave: the pipeline stages and memory controller.
interface memory_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  fetch_enable;
  logic [DATA_WIDTH-1:0] fetch_address;
  logic                  fetch_data_valid;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] read_address;
  logic                  read_data_valid;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_done;
  logic                  mem_enable;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_done;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [1:0]            owner;

  modport master (
    input  fetch_enable, fetch_address, read_enable, read_address,
           write_enable, write_address, write_data, mem_done, mem_rdata,
    output fetch_data_valid, fetch_data, read_data_valid, read_data, write_done,
           mem_enable, mem_write, mem_address, mem_wdata, owner
  );

  modport slave (
    output fetch_enable, fetch_address, read_enable, read_address,
           write_enable, write_address, write_data, mem_done, mem_rdata,
    input  fetch_data_valid, fetch_data, read_data_valid, read_data, write_done,
           mem_enable, mem_write, mem_address, mem_wdata, owner
  );
endinterface

// File: rtl/memory_arbiter.sv
// Single-outstanding arbiter sharing one memory port among fetch, read and write stages.
// Define MEMORY_ARBITER_STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT waiting cycles.
module memory_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic             clock,
  input  logic             reset,
  memory_arbiter_if.master bus
);
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_READ  = 2'd2,
    OWN_WRITE = 2'd3
  } owner_e;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                state_q, state_d;
  owner_e                owner_q, grant;
  logic [DATA_WIDTH-1:0] grant_addr;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q, fetch_data_q, read_data_q;
  logic                  write_q, cancelled_q;
  logic                  fetch_valid_q, read_valid_q, write_done_q;
  logic                  any_req, owner_dropped, fetch_forced;

  if (STARVE_LIMIT == 0) begin : g_bad_limit
    $error("memory_arbiter: STARVE_LIMIT must be at least 1");
  end

  assign any_req = bus.fetch_enable | bus.read_enable | bus.write_enable;

  // Stores are committed once granted, so only fetch and read can be flushed.
  assign owner_dropped = (state_q == BUSY) &&
                         (((owner_q == OWN_FETCH) && !bus.fetch_enable) ||
                          ((owner_q == OWN_READ)  && !bus.read_enable));

`ifdef MEMORY_ARBITER_STARVE_GUARD_EN
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else if (!bus.fetch_enable || ((state_q == IDLE) && (grant == OWN_FETCH))) begin
      starve_q <= '0;
    end else if (!((state_q == BUSY) && (owner_q == OWN_FETCH)) &&
                 (starve_q != CW'(STARVE_LIMIT))) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  assign fetch_forced = bus.fetch_enable && (starve_q >= CW'(STARVE_LIMIT));
`else
  assign fetch_forced = 1'b0;
`endif

  // Older pipeline stages win unless the starvation guard forces fetch.
  always_comb begin
    grant      = OWN_NONE;
    grant_addr = '0;
    if (fetch_forced) begin
      grant      = OWN_FETCH;
      grant_addr = bus.fetch_address;
    end else if (bus.write_enable) begin
      grant      = OWN_WRITE;
      grant_addr = bus.write_address;
    end else if (bus.read_enable) begin
      grant      = OWN_READ;
      grant_addr = bus.read_address;
    end else if (bus.fetch_enable) begin
      grant      = OWN_FETCH;
      grant_addr = bus.fetch_address;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req)      state_d = BUSY;
      BUSY:    if (bus.mem_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q       <= OWN_NONE;
      addr_q        <= '0;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      cancelled_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      read_valid_q  <= 1'b0;
      write_done_q  <= 1'b0;
      fetch_data_q  <= '0;
      read_data_q   <= '0;
    end else begin
      fetch_valid_q <= 1'b0;
      read_valid_q  <= 1'b0;
      write_done_q  <= 1'b0;
      if (state_q == IDLE) begin
        if (any_req) begin
          owner_q     <= grant;
          addr_q      <= grant_addr;
          wdata_q     <= bus.write_data;
          write_q     <= (grant == OWN_WRITE);
          cancelled_q <= 1'b0;
        end
      end else begin
        if (owner_dropped) cancelled_q <= 1'b1;
        // A flush seen in the mem_done cycle itself still suppresses the pulse.
        if (bus.mem_done && !(cancelled_q || owner_dropped)) begin
          case (owner_q)
            OWN_FETCH: begin
              fetch_valid_q <= 1'b1;
              fetch_data_q  <= bus.mem_rdata;
            end
            OWN_READ: begin
              read_valid_q <= 1'b1;
              read_data_q  <= bus.mem_rdata;
            end
            OWN_WRITE: write_done_q <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    bus.mem_enable       = (state_q == BUSY);
    bus.owner            = (state_q == BUSY) ? owner_q : OWN_NONE;
    bus.mem_write        = write_q;
    bus.mem_address      = addr_q;
    bus.mem_wdata        = wdata_q;
    bus.fetch_data_valid = fetch_valid_q;
    bus.fetch_data       = fetch_data_q;
    bus.read_data_valid  = read_valid_q;
    bus.read_data        = read_data_q;
    bus.write_done       = write_done_q;
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model; honours MEMORY_ARBITER_STARVE_GUARD_EN.
module tb_memory_arbiter;
  localparam int unsigned DW    = 32;
  localparam int unsigned LIMIT = 8;
`ifdef MEMORY_ARBITER_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  memory_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  memory_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one in-flight transaction record plus the fetch wait time.
  bit            m_busy, m_write, m_cancel;
  int            m_owner;
  logic [DW-1:0] m_addr, m_wdata, e_fd, e_rd;
  bit            e_fv, e_rv, e_wd;
  int            fetch_wait;

  int            cyc;
  int            mem_cnt, mem_lat_fixed;
  bit            use_fixed_data, spurious_en;
  logic [DW-1:0] mem_data_fixed;
  int            q_owner[$], q_rise[$], q_done[$];
  bit            prev_en;
  bit            f_pend, r_pend, w_pend;

  task automatic model_reset();
    m_busy = 0; m_write = 0; m_cancel = 0; m_owner = 0;
    m_addr = '0; m_wdata = '0; e_fd = '0; e_rd = '0;
    e_fv = 0; e_rv = 0; e_wd = 0;
    fetch_wait = 0;
  endtask

  task automatic model_step();
    bit was_fetch_owner;
    bit fetch_granted;
    was_fetch_owner = m_busy && (m_owner == 1);
    fetch_granted   = 0;
    e_fv = 0; e_rv = 0; e_wd = 0;
    if (reset) begin
      model_reset();
      return;
    end
    if (!m_busy) begin
      if (bus.write_enable || bus.read_enable || bus.fetch_enable) begin
        if (GUARD && bus.fetch_enable && fetch_wait >= int'(LIMIT)) m_owner = 1;
        else if (bus.write_enable) m_owner = 3;
        else if (bus.read_enable)  m_owner = 2;
        else                       m_owner = 1;
        m_busy   = 1;
        m_cancel = 0;
        m_write  = (m_owner == 3);
        m_wdata  = bus.write_data;
        m_addr   = (m_owner == 3) ? bus.write_address :
                   (m_owner == 2) ? bus.read_address : bus.fetch_address;
        fetch_granted = (m_owner == 1);
      end
    end else begin
      if ((m_owner == 1 && !bus.fetch_enable) || (m_owner == 2 && !bus.read_enable))
        m_cancel = 1;
      if (bus.mem_done) begin
        if (!m_cancel) begin
          if (m_owner == 1) begin e_fv = 1; e_fd = bus.mem_rdata; end
          else if (m_owner == 2) begin e_rv = 1; e_rd = bus.mem_rdata; end
          else e_wd = 1;
        end
        m_busy = 0;
      end
    end
    if (!bus.fetch_enable || fetch_granted) fetch_wait = 0;
    else if (!was_fetch_owner) fetch_wait++;
  endtask

  task automatic compare_all();
    check("mem_enable", bus.mem_enable, m_busy);
    check("owner", bus.owner, m_busy ? m_owner : 0);
    if (m_busy) begin
      check("mem_write", bus.mem_write, m_write);
      check("mem_address", bus.mem_address, m_addr);
      check("mem_wdata", bus.mem_wdata, m_wdata);
    end
    check("fetch_data_valid", bus.fetch_data_valid, e_fv);
    check("fetch_data", bus.fetch_data, e_fd);
    check("read_data_valid", bus.read_data_valid, e_rv);
    check("read_data", bus.read_data, e_rd);
    check("write_done", bus.write_done, e_wd);
  endtask

  task automatic memory_drive();
    bus.mem_done = 1'b0;
    if (m_busy) begin
      if (mem_cnt < 0) mem_cnt = (mem_lat_fixed >= 0) ? mem_lat_fixed : int'($urandom_range(0, 3));
      if (mem_cnt == 0) begin
        bus.mem_done  = 1'b1;
        bus.mem_rdata = use_fixed_data ? mem_data_fixed : $urandom;
        mem_cnt       = -1;
        q_done.push_back(cyc);
      end else begin
        mem_cnt--;
      end
    end else if (spurious_en && $urandom_range(0, 7) == 0) begin
      bus.mem_done  = 1'b1;
      bus.mem_rdata = $urandom;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
    model_step();
    compare_all();
    if (bus.mem_enable && !prev_en) begin
      q_owner.push_back(int'(bus.owner));
      q_rise.push_back(cyc);
    end
    prev_en = bus.mem_enable;
    memory_drive();
  endtask

  task automatic settle();
    for (int i = 0; i < 20 && m_busy; i++) tick();
    tick();
  endtask

  task automatic clear_logs();
    q_owner.delete(); q_rise.delete(); q_done.delete();
  endtask

  task automatic drive_requesters(input int p_new, input bit allow_flush);
    bit flushed;
    flushed = 0;
    if (e_fv) f_pend = 0;
    if (e_rv) r_pend = 0;
    if (e_wd) w_pend = 0;
    if (allow_flush && m_busy && $urandom_range(0, 9) == 0) begin
      if (m_owner == 1 && f_pend) begin f_pend = 0; flushed = 1; end
      else if (m_owner == 2 && r_pend) begin r_pend = 0; flushed = 1; end
    end
    if (!flushed) begin
      if (!f_pend && int'($urandom_range(0, 99)) < p_new) begin f_pend = 1; bus.fetch_address = $urandom; end
      if (!r_pend && int'($urandom_range(0, 99)) < p_new) begin r_pend = 1; bus.read_address = $urandom; end
      if (!w_pend && int'($urandom_range(0, 99)) < p_new) begin
        w_pend = 1; bus.write_address = $urandom; bus.write_data = $urandom;
      end
    end
    bus.fetch_enable = f_pend;
    bus.read_enable  = r_pend;
    bus.write_enable = w_pend;
  endtask

  initial begin
    int start, pulse_cyc, pulses, fetch_grants;
    bit got_pulse;

    reset = 1'b1;
    bus.fetch_enable = 0; bus.fetch_address = '0;
    bus.read_enable  = 0; bus.read_address  = '0;
    bus.write_enable = 0; bus.write_address = '0; bus.write_data = '0;
    bus.mem_done     = 0; bus.mem_rdata     = '0;
    model_reset();
    cyc = 0; mem_cnt = -1; mem_lat_fixed = -1; prev_en = 0;
    use_fixed_data = 0; spurious_en = 0; mem_data_fixed = '0;
    f_pend = 0; r_pend = 0; w_pend = 0;

    repeat (2) tick();
    check("reset_mem_enable", bus.mem_enable, 0);
    check("reset_owner", bus.owner, 0);
    check("reset_read_data", bus.read_data, 0);
    reset = 1'b0;
    tick();

    // Single load at 0x40, memory answers three cycles after the request.
    clear_logs();
    mem_lat_fixed = 2; use_fixed_data = 1; mem_data_fixed = 32'hDEADBEEF;
    bus.read_address = 32'h40; bus.read_enable = 1; r_pend = 1;
    start = cyc; got_pulse = 0; pulse_cyc = -1;
    for (int i = 0; i < 20 && !got_pulse; i++) begin
      tick();
      if (bus.read_data_valid) begin got_pulse = 1; pulse_cyc = cyc; end
    end
    check("load_pulse_seen", got_pulse, 1);
    check("load_enable_cycle", (q_rise.size() > 0) ? q_rise[0] - start : -1, 1);
    check("load_pulse_cycle", pulse_cyc - start, 4);
    check("load_data", bus.read_data, 32'hDEADBEEF);
    bus.read_enable = 0; r_pend = 0;
    use_fixed_data = 0;
    settle();

    // Simultaneous requests: write, then read, then fetch, two cycles apart.
    clear_logs();
    mem_lat_fixed = 1;
    bus.write_address = 32'h300; bus.write_data = 32'h1234_5678; bus.write_enable = 1; w_pend = 1;
    bus.read_address  = 32'h200; bus.read_enable  = 1; r_pend = 1;
    bus.fetch_address = 32'h100; bus.fetch_enable = 1; f_pend = 1;
    start = cyc;
    for (int i = 0; i < 40 && (f_pend || r_pend || w_pend); i++) begin
      tick();
      if (e_wd) begin w_pend = 0; bus.write_enable = 0; end
      if (e_rv) begin r_pend = 0; bus.read_enable  = 0; end
      if (e_fv) begin f_pend = 0; bus.fetch_enable = 0; end
    end
    check("order_grant_count", q_owner.size(), 3);
    if (q_owner.size() == 3 && q_done.size() >= 2) begin
      check("order_first_write", q_owner[0], 3);
      check("order_second_read", q_owner[1], 2);
      check("order_third_fetch", q_owner[2], 1);
      check("order_first_start", q_rise[0] - start, 1);
      check("order_gap_1", q_rise[1] - q_done[0], 2);
      check("order_gap_2", q_rise[2] - q_done[1], 2);
    end
    settle();

    // Flush: read granted, then dropped before the memory completes.
    mem_lat_fixed = 4;
    bus.read_address = 32'h44; bus.read_enable = 1; r_pend = 1;
    tick(); tick();
    bus.read_enable = 0; r_pend = 0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.read_data_valid) pulses++;
    end
    check("flush_no_pulse", pulses, 0);
    check("flush_idle_enable", bus.mem_enable, 0);
    check("flush_idle_owner", bus.owner, 0);

    // Reset while a store is in flight.
    mem_lat_fixed = 5;
    bus.write_address = 32'h500; bus.write_data = 32'hCAFE_F00D; bus.write_enable = 1; w_pend = 1;
    tick(); tick();
    reset = 1'b1;
    #1;
    check("rst_busy_mem_enable", bus.mem_enable, 0);
    check("rst_busy_mem_write", bus.mem_write, 0);
    check("rst_busy_mem_address", bus.mem_address, 0);
    check("rst_busy_mem_wdata", bus.mem_wdata, 0);
    check("rst_busy_owner", bus.owner, 0);
    check("rst_busy_write_done", bus.write_done, 0);
    check("rst_busy_fetch_data", bus.fetch_data, 0);
    model_reset(); mem_cnt = -1;
    bus.write_enable = 0; w_pend = 0;
    tick();
    reset = 1'b0;
    bus.mem_done = 1; bus.mem_rdata = 32'hBAD0_BAD0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.fetch_data_valid || bus.read_data_valid || bus.write_done || bus.mem_enable) pulses++;
    end
    check("rst_late_done_ignored", pulses, 0);

    // Read held continuously while fetch waits.
    clear_logs();
    mem_lat_fixed = 1;
    bus.fetch_address = 32'h1000; bus.fetch_enable = 1; f_pend = 1;
    bus.read_address  = 32'h2000; bus.read_enable  = 1; r_pend = 1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (e_rv) bus.read_address = $urandom;
      if (e_fv) begin f_pend = 0; bus.fetch_enable = 0; end
    end
    fetch_grants = 0;
    foreach (q_owner[i]) if (q_owner[i] == 1) fetch_grants++;
    check("starve_fetch_granted", fetch_grants > 0, GUARD);
    bus.read_enable = 0; r_pend = 0; bus.fetch_enable = 0; f_pend = 0;
    settle();

    // Random traffic with flushes, variable latency and stray mem_done.
    mem_lat_fixed = -1; spurious_en = 1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      drive_requesters(30, 1'b1);
    end
    spurious_en = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      drive_requesters(0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
